// File: rtl/ysyx_040066_if_fetch.sv
// ysyx_040066_if_fetch -- instruction fetch stage.
// Takes one fetch PC at a time from the PC stage and issues a single 64-bit
// aligned read. It then selects the 32-bit word and queues {pc, inst, fault}
// for ID. It also back-pressures the PC stage and discards stale work on a
// redirect flush.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pc_i, pc_valid_i      fetch PC from PC stage
//   flush_i               redirect: empties the queue, kills the in-flight fetch
//   fetch_block_o         PC stage must hold its PC this cycle
//   mem_req_*             read request (valid/ready, 8-byte aligned address)
//   mem_rsp_*             read response (valid, data, access fault)
//   id_*                  queue head towards decode; id_ready_i pops it
module ysyx_040066_if_fetch #(
  parameter int unsigned DEPTH        = 2,
  parameter logic [63:0] RESET_PC_CHK = 64'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_i,
  input  logic        pc_valid_i,
  input  logic        flush_i,
  output logic        fetch_block_o,
  output logic        mem_req_valid_o,
  output logic [63:0] mem_req_addr_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rsp_valid_i,
  input  logic [63:0] mem_rsp_data_i,
  input  logic        mem_rsp_err_i,
  output logic        id_valid_o,
  output logic [63:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_fault_o,
  input  logic        id_ready_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e         state_q, state_d;
  logic           kill_q, kill_d;
  logic [63:0]    pc_q, pc_d;

  logic [63:0]    q_pc    [DEPTH];
  logic [31:0]    q_inst  [DEPTH];
  logic           q_fault [DEPTH];
  logic [AW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;

  logic           accept, deq, enq, enq_ok, full;
  logic [63:0]    enq_pc;
  logic [31:0]    enq_inst;
  logic           enq_fault;

  assign full          = (count_q == CW'(DEPTH));
  // Blocking in every non-IDLE state keeps at most one fetch outstanding, so
  // count<DEPTH at accept already reserves the slot for its response.
  assign fetch_block_o = (state_q != S_IDLE) | full;
  assign accept        = pc_valid_i & ~fetch_block_o & ~flush_i;
  assign deq           = id_valid_o & id_ready_i & ~flush_i;
  assign enq_ok        = enq & (~full | deq);

  assign mem_req_addr_o = {pc_q[63:3], 3'b000};
  assign id_valid_o     = (count_q != '0);
  assign id_pc_o        = q_pc[head_q];
  assign id_inst_o      = q_inst[head_q];
  assign id_fault_o     = q_fault[head_q];

  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    pc_d            = pc_q;
    enq             = 1'b0;
    enq_pc          = pc_q;
    enq_inst        = '0;
    enq_fault       = 1'b0;
    mem_req_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (pc_i[1:0] != 2'b00) begin
            // Misaligned PC faults locally without touching memory.
            enq       = 1'b1;
            enq_pc    = pc_i;
            enq_fault = 1'b1;
          end else begin
            pc_d    = pc_i;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          // A flush on the handshake cycle itself must also kill the response.
          kill_d  = kill_q | flush_i;
          state_d = (kill_q | flush_i) ? S_DRAIN : S_WAIT;
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid_i) begin
          state_d = S_IDLE;
          if (!flush_i) begin
            enq       = 1'b1;
            enq_inst  = pc_q[2] ? mem_rsp_data_i[63:32] : mem_rsp_data_i[31:0];
            enq_fault = mem_rsp_err_i;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid_i) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_ok) tail_q <= tail_q + 1'b1;
      if (deq)    head_q <= head_q + 1'b1;
      unique case ({enq_ok, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok && !flush_i) begin
      q_pc[tail_q]    <= enq_pc;
      q_inst[tail_q]  <= enq_inst;
      q_fault[tail_q] <= enq_fault;
    end
  end

`ifndef SYNTHESIS
  logic boot_q;
  always_ff @(posedge clk) begin
    if (rst) boot_q <= 1'b1;
    else if (accept) boot_q <= 1'b0;
    // The first fetch after reset must be the expected boot PC.
    if (!rst && boot_q && accept) assert (pc_i == RESET_PC_CHK);
    // Request held stable until the handshake.
    if (!rst && state_q == S_REQ && !mem_req_ready_i) assert (state_d == S_REQ);
  end
`endif

endmodule

// File: tb/tb_ysyx_040066_if_fetch.sv
module tb_ysyx_040066_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_block_o;
  logic        mem_req_valid_o;
  logic [63:0] mem_req_addr_o;
  logic        mem_req_ready_i = 1'b1;
  logic        mem_rsp_valid_i = 1'b0;
  logic [63:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        id_valid_o;
  logic [63:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_fault_o;
  logic        id_ready_i = 1'b1;

  ysyx_040066_if_fetch #(.DEPTH(2), .RESET_PC_CHK(64'h3000_0000)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .flush_i(flush_i),
    .fetch_block_o(fetch_block_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_err_i(mem_rsp_err_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_fault_o(id_fault_o), .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } id_t;

  id_t         exp_id_q[$];
  logic [63:0] exp_addr_q[$];
  int vectors = 0;
  int miscompares = 0;
  int req_count = 0;

  logic [63:0] rsp_data  = '0;
  logic        rsp_err   = 1'b0;
  int          rsp_delay = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_id(input logic [63:0] pc, input logic [31:0] inst, input logic fault);
    id_t e;
    e.pc = pc; e.inst = inst; e.fault = fault;
    exp_id_q.push_back(e);
  endtask

  // Holds pc_valid_i until the DUT is able to accept, then drops it.
  task automatic do_fetch(input logic [63:0] pc);
    int n;
    n = 0;
    pc_i = pc;
    pc_valid_i = 1'b1;
    while (fetch_block_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL fetch_timeout pc=%h: still blocked after %0d cycles, expected accept", pc, n);
    end
    tick();
    pc_valid_i = 1'b0;
  endtask

  // Memory model: one response, rsp_delay cycles after the nominal slot.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_req_valid_o && mem_req_ready_i) begin
        int d;
        d = rsp_delay;
        tick();
        repeat (d) tick();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = rsp_data;
        mem_rsp_err_i   = rsp_err;
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
      end
    end
  end

  // Monitor: compares every request handshake and every ID pop against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_req_valid_o && mem_req_ready_i) begin
        req_count++;
        if (exp_addr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL mem_req: unexpected request addr %h, expected none", mem_req_addr_o);
        end else begin
          chk("mem_req_addr", mem_req_addr_o, exp_addr_q.pop_front());
        end
      end
      if (!rst && id_valid_o && id_ready_i && !flush_i) begin
        if (exp_id_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL id_out: unexpected entry pc=%h inst=%h fault=%b, expected none",
                   id_pc_o, id_inst_o, id_fault_o);
        end else begin
          id_t e;
          id_t a;
          e = exp_id_q.pop_front();
          a.pc = id_pc_o; a.inst = id_inst_o; a.fault = id_fault_o;
          vectors++;
          if (a !== e) begin
            miscompares++;
            $display("FAIL id_out: got pc=%h inst=%h fault=%b expected pc=%h inst=%h fault=%b",
                     a.pc, a.inst, a.fault, e.pc, e.inst, e.fault);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset
    rst = 1'b1;
    tick();
    chk("rst_id_valid", 64'(id_valid_o), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_req_addr", mem_req_addr_o, 64'd0);
    chk("rst_fetch_block", 64'(fetch_block_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Aligned fetch, low word, minimum latency
    rsp_data = 64'h0000_0093_0000_0513;
    exp_addr_q.push_back(64'h3000_0000);
    push_id(64'h3000_0000, 32'h0000_0513, 1'b0);
    do_fetch(64'h3000_0000);                    // now in T+1
    chk("lat_req_valid_T1", 64'(mem_req_valid_o), 64'd1);
    chk("lat_req_addr_T1", mem_req_addr_o, 64'h3000_0000);
    chk("lat_block_T1", 64'(fetch_block_o), 64'd1);
    tick();                                     // T+2
    chk("lat_id_valid_T2", 64'(id_valid_o), 64'd0);
    tick();                                     // T+3
    chk("lat_id_valid_T3", 64'(id_valid_o), 64'd1);
    repeat (2) tick();

    // High word select
    exp_addr_q.push_back(64'h3000_0000);
    push_id(64'h3000_0004, 32'h0000_0093, 1'b0);
    do_fetch(64'h3000_0004);
    repeat (4) tick();

    // Queue fills with ID stalled
    id_ready_i = 1'b0;
    base = req_count;
    exp_addr_q.push_back(64'h3000_0000);
    push_id(64'h3000_0000, 32'h0000_0513, 1'b0);
    exp_addr_q.push_back(64'h3000_0000);
    push_id(64'h3000_0004, 32'h0000_0093, 1'b0);
    exp_addr_q.push_back(64'h3000_0008);
    push_id(64'h3000_0008, 32'h0000_0513, 1'b0);
    do_fetch(64'h3000_0000);
    do_fetch(64'h3000_0004);
    pc_i = 64'h3000_0008;
    pc_valid_i = 1'b1;
    repeat (5) tick();
    chk("full_block", 64'(fetch_block_o), 64'd1);
    chk("full_head_pc", id_pc_o, 64'h3000_0000);
    chk("full_req_count", 64'(req_count - base), 64'd2);
    id_ready_i = 1'b1;
    do_fetch(64'h3000_0008);
    repeat (6) tick();
    chk("full_drained", 64'(id_valid_o), 64'd0);

    // Flush in WAIT, response arrives two cycles later
    rsp_delay = 2;
    exp_addr_q.push_back(64'h3000_0040);
    do_fetch(64'h3000_0040);                    // T+1 (REQ, handshake)
    tick();                                     // T+2 WAIT
    flush_i = 1'b1;
    tick();                                     // T+3 DRAIN
    flush_i = 1'b0;
    tick();                                     // T+4 response present
    chk("wflush_block_during", 64'(fetch_block_o), 64'd1);
    tick();                                     // T+5
    chk("wflush_block_after", 64'(fetch_block_o), 64'd0);
    chk("wflush_id_valid", 64'(id_valid_o), 64'd0);
    rsp_delay = 0;
    rsp_data = 64'hdead_beef_0010_0073;
    exp_addr_q.push_back(64'h3000_0100);
    push_id(64'h3000_0100, 32'h0010_0073, 1'b0);
    do_fetch(64'h3000_0100);
    repeat (4) tick();

    // Flush in REQ with memory not ready for three cycles
    mem_req_ready_i = 1'b0;
    exp_addr_q.push_back(64'h3000_0200);
    do_fetch(64'h3000_0200);                    // T+1 REQ
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rflush_req_valid", 64'(mem_req_valid_o), 64'd1);
      chk("rflush_req_addr", mem_req_addr_o, 64'h3000_0200);
      tick();
    end
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("rflush_id_valid", 64'(id_valid_o), 64'd0);
      tick();
    end
    chk("rflush_block_after", 64'(fetch_block_o), 64'd0);

    // Misaligned PC faults without a memory request
    push_id(64'h3000_0002, 32'h0, 1'b1);
    do_fetch(64'h3000_0002);
    chk("mis_req_valid", 64'(mem_req_valid_o), 64'd0);
    chk("mis_id_valid", 64'(id_valid_o), 64'd1);
    chk("mis_id_fault", 64'(id_fault_o), 64'd1);
    chk("mis_id_inst", 64'(id_inst_o), 64'd0);
    repeat (2) tick();

    // Access fault on a normal fetch, high word
    rsp_data = 64'h1111_2222_3333_4444;
    rsp_err  = 1'b1;
    exp_addr_q.push_back(64'h3000_0008);
    push_id(64'h3000_000C, 32'h1111_2222, 1'b1);
    do_fetch(64'h3000_000C);
    repeat (5) tick();
    rsp_err = 1'b0;

    chk("sb_id_empty", 64'(exp_id_q.size()), 64'd0);
    chk("sb_addr_empty", 64'(exp_addr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
